// File: rtl/fpadd_sched_pkg.sv
// fpadd_sched_pkg: shared types and constants for the fpadder scheduler.
// Contents: sched_state_t FSM states, FP_W operand width, FP_NAN error/NaN pattern.
package fpadd_sched_pkg;
  localparam int FP_W = 32;
  localparam logic [FP_W-1:0] FP_NAN = 32'hFFFFFFFF;
  typedef enum logic [2:0] {IDLE, SYNC, OPA, OPB, WAIT, RESP} sched_state_t;
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin arbiter whose search starts one past the last grant.
// Ports: clock, reset (sync, active-high); req requests; advance commits a grant
// and moves the pointer; grant one-hot winner; grant_id binary winner.
module rr_arbiter #(
  parameter int NREQ = 2
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req,
  input  logic                    advance,
  output logic [NREQ-1:0]         grant,
  output logic [$clog2(NREQ)-1:0] grant_id
);
  localparam int IW = $clog2(NREQ);
  logic [IW-1:0] ptr;
  // Scan farthest-to-nearest so the requester closest after ptr is assigned last and wins.
  always_comb begin
    grant = '0;
    grant_id = '0;
    for (int k = NREQ; k >= 1; k--) begin
      automatic logic [IW-1:0] j;
      j = IW'((int'(ptr) + k) % NREQ);
      if (req[j]) begin
        grant = '0;
        grant[j] = 1'b1;
        grant_id = j;
      end
    end
  end
  // Pointer starts at NREQ-1 so requester 0 wins first after reset.
  always_ff @(posedge clock)
    if (reset) ptr <= IW'(NREQ - 1);
    else if (advance && |req) ptr <= grant_id;
endmodule

// File: rtl/fpadd_scheduler.sv
// fpadd_scheduler: shares one free-running fpadder between NREQ requesters.
// Ports: clock, reset (sync, active-high); req_valid/req_ready/req_opa/req_opb
// per-requester operand handshake; rsp_valid/rsp_ready/rsp_id/rsp_sum result
// handshake; add_a/add_ready/add_sum/add_nreset connect to the fpadder.
// Build macro FPADD_SCHED_TIMEOUT_EN adds a SYNC/WAIT watchdog and rsp_err.
module fpadd_scheduler
  import fpadd_sched_pkg::*;
#(
  parameter int NREQ = 2,
  parameter int TIMEOUT = 64
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ-1:0][FP_W-1:0] req_opa,
  input  logic [NREQ-1:0][FP_W-1:0] req_opb,
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [$clog2(NREQ)-1:0]   rsp_id,
  output logic [FP_W-1:0]           rsp_sum,
`ifdef FPADD_SCHED_TIMEOUT_EN
  output logic                      rsp_err,
`endif
  output logic [FP_W-1:0]           add_a,
  input  logic                      add_ready,
  input  logic [FP_W-1:0]           add_sum,
  output logic                      add_nreset
);
  localparam int IW = $clog2(NREQ);
  sched_state_t state, nextState;
  logic [FP_W-1:0] opaQ, opbQ, sumQ;
  logic [IW-1:0] idQ, grantId;
  logic [NREQ-1:0] grant;
  logic idle, fire, nresQ;
  assign idle = state == IDLE && !reset;
  rr_arbiter #(.NREQ(NREQ)) arb (
    .clock(clock),
    .reset(reset),
    .req(req_valid),
    .advance(idle),
    .grant(grant),
    .grant_id(grantId)
  );
  assign req_ready = idle ? grant : '0;
  assign rsp_valid = state == RESP;
  assign rsp_sum = sumQ;
  assign rsp_id = idQ;
  assign add_a = state == OPA ? opaQ : state == OPB ? opbQ : '0;
  // Held low combinationally during reset, then for one registered cycle after it or a watchdog fire.
  assign add_nreset = nresQ && !reset;
`ifdef FPADD_SCHED_TIMEOUT_EN
  logic [$clog2(TIMEOUT + 1)-1:0] wdCnt;
  logic errQ;
  // A ready pulse arriving on the limit cycle still wins over the timeout.
  assign fire = (state == SYNC || state == WAIT) && !add_ready && wdCnt == ($bits(wdCnt))'(TIMEOUT - 1);
  assign rsp_err = errQ;
  always_ff @(posedge clock)
    if (reset) begin
      wdCnt <= '0;
      errQ <= 1'b0;
    end else begin
      wdCnt <= (state == SYNC || state == WAIT) ? wdCnt + 1'b1 : '0;
      errQ <= fire ? 1'b1 : (state == RESP && rsp_ready) ? 1'b0 : errQ;
    end
`else
  // Without the watchdog TIMEOUT is inert; this compare is constant false for legal values.
  assign fire = TIMEOUT < 0;
`endif
  always_ff @(posedge clock)
    if (reset) begin
      state <= IDLE;
      opaQ <= '0;
      opbQ <= '0;
      idQ <= '0;
      sumQ <= '0;
      nresQ <= 1'b0;
    end else begin
      state <= nextState;
      nresQ <= !fire;
      if (idle && |req_valid) begin
        opaQ <= req_opa[grantId];
        opbQ <= req_opb[grantId];
        idQ <= grantId;
      end
      if (fire) sumQ <= FP_NAN;
      else if (state == WAIT && add_ready) sumQ <= add_sum;
    end
  always_comb begin
    nextState = state;
    unique case (state)
      IDLE: if (|req_valid) nextState = add_ready ? OPA : SYNC;
      SYNC: if (add_ready) nextState = OPA;
      OPA: nextState = OPB;
      OPB: nextState = WAIT;
      WAIT: if (add_ready) nextState = RESP;
      RESP: if (rsp_ready) nextState = IDLE;
      default: nextState = IDLE;
    endcase
    if (fire) nextState = RESP;
  end
endmodule
